// File: rtl/rgmii_frame_rx_if.sv
// Signal bundle of the RGMII frame receiver: RGMII receive pins on one side,
// payload-RAM write port and frame status on the other.
interface rgmii_frame_rx_if #(
    parameter int AW = 10
);
    logic          rxctl;
    logic [3:0]    rxd;
    logic [AW:0]   rxad;
    logic          rxwe;
    logic [7:0]    rxdata;
    logic          idx;
    logic [15:0]   seq;
    logic          frame_ok;
    logic          frame_err;
    logic [2:0]    err_code;

    modport master (
        output rxctl, rxd,
        input  rxad, rxwe, rxdata, idx, seq, frame_ok, frame_err, err_code
    );

    modport slave (
        input  rxctl, rxd,
        output rxad, rxwe, rxdata, idx, seq, frame_ok, frame_err, err_code
    );
endinterface

// File: rtl/rgmii_frame_rx.sv
// RGMII receiver for the fixed-format raw-Ethernet link: captures DDR bytes, checks the
// header and CRC-32, writes the payload into a double-buffered RAM and commits good frames.
module rgmii_frame_rx #(
    parameter logic [47:0] OWN_MAC       = 48'h88_dab8_bf08,
    parameter logic [15:0] ETHERTYPE     = 16'h1919,
    parameter int          PAYLOAD_BYTES = 1024
) (
    input logic             clk125,
    input logic             rst,
    rgmii_frame_rx_if.slave bus
);

    localparam int AW = $clog2(PAYLOAD_BYTES);
    localparam int NW = $clog2(PAYLOAD_BYTES + 20);

    localparam logic [NW-1:0] N_MAC_END   = NW'(6);
    localparam logic [NW-1:0] N_TYPE_HI   = NW'(12);
    localparam logic [NW-1:0] N_TYPE_LO   = NW'(13);
    localparam logic [NW-1:0] N_SEQ_LO    = NW'(14);
    localparam logic [NW-1:0] N_SEQ_HI    = NW'(15);
    localparam logic [NW-1:0] N_PAY_FIRST = NW'(16);
    localparam logic [NW-1:0] N_PAY_LAST  = NW'(PAYLOAD_BYTES + 15);
    localparam logic [NW-1:0] N_FCS_LAST  = NW'(PAYLOAD_BYTES + 19);

    localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;

    localparam logic [2:0] ERR_PRE   = 3'd1;
    localparam logic [2:0] ERR_MAC   = 3'd2;
    localparam logic [2:0] ERR_TYPE  = 3'd3;
    localparam logic [2:0] ERR_LEN   = 3'd4;
    localparam logic [2:0] ERR_CRC   = 3'd5;
    localparam logic [2:0] ERR_RGMII = 3'd6;

    typedef enum logic [2:0] {
        S_WAIT_IDLE, S_IDLE, S_PRE, S_HDR, S_PAY, S_FCS, S_CHK, S_DROP
    } state_t;

    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'd0, b};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
        end
        return r;
    endfunction

    function automatic logic [7:0] own_mac_byte(input logic [2:0] k);
        case (k)
            3'd0:    return OWN_MAC[7:0];
            3'd1:    return OWN_MAC[15:8];
            3'd2:    return OWN_MAC[23:16];
            3'd3:    return OWN_MAC[31:24];
            3'd4:    return OWN_MAC[39:32];
            3'd5:    return OWN_MAC[47:40];
            default: return 8'h00;
        endcase
    endfunction

    // DDR capture: low nibble and DV on the rising edge, high nibble and DV^ER on the falling edge
    logic [3:0] lo_q, hi_q;
    logic       dv_q, dver_q;
    logic [7:0] rx_byte_q;
    logic       valid_q, err_q;

    always_ff @(posedge clk125) begin
        lo_q <= bus.rxd;
        dv_q <= bus.rxctl;
    end

    always_ff @(negedge clk125) begin
        hi_q   <= bus.rxd;
        dver_q <= bus.rxctl;
    end

    always_ff @(posedge clk125) begin
        rx_byte_q <= {hi_q, lo_q};
        valid_q   <= dv_q;
        err_q     <= dv_q ^ dver_q;
    end

    // Frame parser
    state_t        state_q, state_d;
    logic [NW-1:0] n_q, n_d;
    logic [31:0]   crc_q, crc_d;
    logic          own_ok_q, own_ok_d, bc_ok_q, bc_ok_d;
    logic [15:0]   pend_seq_q, pend_seq_d;
    logic [2:0]    drop_code_q, drop_code_d;
    logic          wbank_q, wbank_d;
    logic          idx_q, idx_d;
    logic [15:0]   seq_q, seq_d;
    logic          rxwe_q, rxwe_d;
    logic [AW:0]   rxad_q, rxad_d;
    logic [7:0]    rxdata_q, rxdata_d;
    logic          frame_ok_q, frame_ok_d;
    logic          frame_err_q, frame_err_d;
    logic [2:0]    err_code_q, err_code_d;

    always_comb begin
        logic start_hdr;
        logic own_hit, bc_hit;
        state_d     = state_q;
        n_d         = n_q;
        crc_d       = crc_q;
        own_ok_d    = own_ok_q;
        bc_ok_d     = bc_ok_q;
        pend_seq_d  = pend_seq_q;
        drop_code_d = drop_code_q;
        wbank_d     = wbank_q;
        idx_d       = idx_q;
        seq_d       = seq_q;
        rxwe_d      = 1'b0;
        rxad_d      = rxad_q;
        rxdata_d    = rxdata_q;
        frame_ok_d  = 1'b0;
        frame_err_d = 1'b0;
        err_code_d  = err_code_q;
        start_hdr   = 1'b0;
        own_hit     = (rx_byte_q == own_mac_byte(n_q[2:0]));
        bc_hit      = (rx_byte_q == 8'hFF);

        case (state_q)
            S_WAIT_IDLE: if (!valid_q) state_d = S_IDLE;
            S_IDLE, S_PRE: begin
                if (!valid_q) begin
                    state_d = S_IDLE;
                end else if (rx_byte_q == 8'h55) begin
                    state_d = S_PRE;
                end else if (rx_byte_q == 8'hD5) begin
                    start_hdr = 1'b1;
                end else begin
                    state_d     = S_DROP;
                    drop_code_d = ERR_PRE;
                end
            end
            S_HDR, S_PAY, S_FCS: begin
                if (!valid_q) begin
                    frame_err_d = 1'b1;
                    err_code_d  = ERR_LEN;
                    state_d     = S_IDLE;
                end else if (err_q) begin
                    state_d     = S_DROP;
                    drop_code_d = ERR_RGMII;
                end else begin
                    crc_d = crc_step(crc_q, rx_byte_q);
                    n_d   = n_q + NW'(1);
                    if (state_q == S_HDR) begin
                        if (n_q < N_MAC_END) begin
                            own_ok_d = own_ok_q & own_hit;
                            bc_ok_d  = bc_ok_q & bc_hit;
                            if (!(own_ok_q & own_hit) && !(bc_ok_q & bc_hit)) begin
                                state_d     = S_DROP;
                                drop_code_d = ERR_MAC;
                            end
                        end else if ((n_q == N_TYPE_HI && rx_byte_q != ETHERTYPE[15:8]) ||
                                     (n_q == N_TYPE_LO && rx_byte_q != ETHERTYPE[7:0])) begin
                            state_d     = S_DROP;
                            drop_code_d = ERR_TYPE;
                        end else if (n_q == N_SEQ_LO) begin
                            pend_seq_d[7:0] = rx_byte_q;
                        end else if (n_q == N_SEQ_HI) begin
                            pend_seq_d[15:8] = rx_byte_q;
                            state_d          = S_PAY;
                        end
                    end else if (state_q == S_PAY) begin
                        rxwe_d   = 1'b1;
                        rxdata_d = rx_byte_q;
                        rxad_d   = {wbank_q, AW'(n_q - N_PAY_FIRST)};
                        if (n_q == N_PAY_LAST) state_d = S_FCS;
                    end else if (n_q == N_FCS_LAST) begin
                        state_d = S_CHK;
                    end
                end
            end
            S_CHK: begin
                if (valid_q) begin
                    state_d     = S_DROP;
                    drop_code_d = ERR_LEN;
                end else if (crc_q == CRC_RESIDUE) begin
                    frame_ok_d = 1'b1;
                    idx_d      = wbank_q;
                    seq_d      = pend_seq_q;
                    wbank_d    = ~wbank_q;
                    state_d    = S_IDLE;
                end else begin
                    frame_err_d = 1'b1;
                    err_code_d  = ERR_CRC;
                    state_d     = S_IDLE;
                end
            end
            S_DROP: begin
                if (!valid_q) begin
                    frame_err_d = 1'b1;
                    err_code_d  = drop_code_q;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_WAIT_IDLE;
        endcase

        if (start_hdr) begin
            state_d  = S_HDR;
            n_d      = '0;
            crc_d    = CRC_INIT;
            own_ok_d = 1'b1;
            bc_ok_d  = 1'b1;
        end
    end

    // Control and outputs reset; per-frame datapath state is reloaded at every SFD
    always_ff @(posedge clk125) begin
        if (rst) begin
            state_q     <= S_WAIT_IDLE;
            wbank_q     <= 1'b1;
            idx_q       <= 1'b0;
            seq_q       <= '0;
            rxwe_q      <= 1'b0;
            rxad_q      <= '0;
            rxdata_q    <= '0;
            frame_ok_q  <= 1'b0;
            frame_err_q <= 1'b0;
            err_code_q  <= '0;
        end else begin
            state_q     <= state_d;
            wbank_q     <= wbank_d;
            idx_q       <= idx_d;
            seq_q       <= seq_d;
            rxwe_q      <= rxwe_d;
            rxad_q      <= rxad_d;
            rxdata_q    <= rxdata_d;
            frame_ok_q  <= frame_ok_d;
            frame_err_q <= frame_err_d;
            err_code_q  <= err_code_d;
        end
        n_q         <= n_d;
        crc_q       <= crc_d;
        own_ok_q    <= own_ok_d;
        bc_ok_q     <= bc_ok_d;
        pend_seq_q  <= pend_seq_d;
        drop_code_q <= drop_code_d;
    end

    assign bus.rxad      = rxad_q;
    assign bus.rxwe      = rxwe_q;
    assign bus.rxdata    = rxdata_q;
    assign bus.idx       = idx_q;
    assign bus.seq       = seq_q;
    assign bus.frame_ok  = frame_ok_q;
    assign bus.frame_err = frame_err_q;
    assign bus.err_code  = err_code_q;

endmodule

// File: tb/tb_rgmii_frame_rx.sv
// Scoreboard bench for rgmii_frame_rx: frames are built with a reference FCS, expected RAM
// writes and status pulses are queued at send time and matched as the DUT produces them.
module tb_rgmii_frame_rx;

    localparam logic [47:0] OWN = 48'h88_dab8_bf08;
    localparam logic [47:0] BC  = 48'hFFFF_FFFF_FFFF;
    localparam logic [47:0] BAD = 48'h01_0000_0000_02;

    logic clk125 = 1'b0;
    logic rst    = 1'b1;
    always #4 clk125 = ~clk125;

    rgmii_frame_rx_if bus ();

    rgmii_frame_rx dut (
        .clk125 (clk125),
        .rst    (rst),
        .bus    (bus)
    );

    typedef struct packed {
        logic [10:0] ad;
        logic [7:0]  d;
    } wr_t;

    typedef struct packed {
        logic        ok;
        logic [2:0]  code;
        logic        idx;
        logic [15:0] seq;
    } ev_t;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  fr[$];
    wr_t         wr_q[$];
    ev_t         ev_q[$];
    bit          ignore_wr = 1'b0;
    logic        wbank_m, idx_m;
    logic [15:0] seq_m;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Bit-serial reference CRC over the frame body, returned as the FCS to transmit
    function automatic logic [31:0] fcs_of_frame();
        logic [31:0] c = 32'hFFFF_FFFF;
        logic        fb;
        for (int k = 0; k < fr.size(); k++) begin
            for (int b = 0; b < 8; b++) begin
                fb = c[0] ^ fr[k][b];
                c  = c >> 1;
                if (fb) c = c ^ 32'hEDB8_8320;
            end
        end
        return ~c;
    endfunction

    task automatic build(input logic [47:0] dst, input logic [15:0] typ,
                         input logic [15:0] sq, input int pat);
        logic [31:0] fcs;
        fr.delete();
        for (int k = 0; k < 6; k++) fr.push_back(dst[8*k +: 8]);
        for (int k = 0; k < 6; k++) fr.push_back(8'h66);
        fr.push_back(typ[15:8]);
        fr.push_back(typ[7:0]);
        fr.push_back(sq[7:0]);
        fr.push_back(sq[15:8]);
        for (int i = 0; i < 1024; i++) fr.push_back(8'((i + pat) & 8'hFF));
        fcs = fcs_of_frame();
        for (int k = 0; k < 4; k++) fr.push_back(fcs[8*k +: 8]);
    endtask

    task automatic reset_model();
        wbank_m = 1'b1;
        idx_m   = 1'b0;
        seq_m   = 16'h0000;
    endtask

    task automatic exp_writes(input int cnt);
        wr_t w;
        for (int i = 0; i < cnt; i++) begin
            w.ad = {wbank_m, i[9:0]};
            w.d  = fr[16+i];
            wr_q.push_back(w);
        end
    endtask

    task automatic exp_ok();
        ev_t e;
        e.ok   = 1'b1;
        e.code = 3'd0;
        e.idx  = wbank_m;
        e.seq  = {fr[15], fr[14]};
        ev_q.push_back(e);
        idx_m   = wbank_m;
        seq_m   = e.seq;
        wbank_m = ~wbank_m;
    endtask

    task automatic exp_err(input logic [2:0] code);
        ev_t e;
        e.ok   = 1'b0;
        e.code = code;
        e.idx  = idx_m;
        e.seq  = seq_m;
        ev_q.push_back(e);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic dv, input logic er);
        @(negedge clk125);
        #1;
        bus.rxd   = b[3:0];
        bus.rxctl = dv;
        @(posedge clk125);
        #1;
        bus.rxd   = b[7:4];
        bus.rxctl = dv ^ er;
    endtask

    task automatic send_frame(input int cut, input int er_at, input int rst_at, input int gap);
        repeat (7) send_byte(8'h55, 1'b1, 1'b0);
        send_byte(8'hD5, 1'b1, 1'b0);
        for (int i = 0; i < fr.size() && (cut < 0 || i < cut); i++) begin
            if (rst_at >= 0 && i == rst_at) rst = 1'b1;
            if (rst_at >= 0 && i == rst_at + 1) begin
                rst = 1'b0;
                reset_model();
            end
            if (rst_at >= 0 && i == rst_at + 4) ignore_wr = 1'b0;
            send_byte(fr[i], 1'b1, (i == er_at));
        end
        repeat (gap) send_byte(8'h00, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        repeat (6) send_byte(8'h00, 1'b0, 1'b0);
        rst = 1'b1;
        repeat (2) send_byte(8'h00, 1'b0, 1'b0);
        rst = 1'b0;
        reset_model();
        repeat (2) send_byte(8'h00, 1'b0, 1'b0);
    endtask

    always @(negedge clk125) begin
        if (bus.rxwe === 1'b1 && !ignore_wr) begin
            if (wr_q.size() == 0) begin
                check_val("unexpected_rxwe", 32'(bus.rxwe), 32'd0);
            end else begin
                wr_t w;
                w = wr_q.pop_front();
                check_val("rxad", 32'(bus.rxad), 32'(w.ad));
                check_val("rxdata", 32'(bus.rxdata), 32'(w.d));
            end
        end
        if (bus.frame_ok === 1'b1 && bus.frame_err === 1'b1)
            check_val("ok_err_same_cycle", 32'(bus.frame_err), 32'd0);
        if (bus.frame_ok === 1'b1 || bus.frame_err === 1'b1) begin
            if (ev_q.size() == 0) begin
                check_val("unexpected_pulse", 32'({bus.frame_ok, bus.frame_err}), 32'd0);
            end else begin
                ev_t e;
                e = ev_q.pop_front();
                check_val("frame_ok", 32'(bus.frame_ok), 32'(e.ok));
                if (!e.ok) check_val("err_code", 32'(bus.err_code), 32'(e.code));
                check_val("idx", 32'(bus.idx), 32'(e.idx));
                check_val("seq", 32'(bus.seq), 32'(e.seq));
            end
        end
    end

    initial begin
        bus.rxctl = 1'b0;
        bus.rxd   = 4'h0;
        rst       = 1'b1;
        reset_model();
        repeat (4) send_byte(8'h00, 1'b0, 1'b0);
        check_val("rst_rxwe", 32'(bus.rxwe), 32'd0);
        check_val("rst_rxad", 32'(bus.rxad), 32'd0);
        check_val("rst_rxdata", 32'(bus.rxdata), 32'd0);
        check_val("rst_idx", 32'(bus.idx), 32'd0);
        check_val("rst_seq", 32'(bus.seq), 32'd0);
        check_val("rst_frame_ok", 32'(bus.frame_ok), 32'd0);
        check_val("rst_frame_err", 32'(bus.frame_err), 32'd0);
        check_val("rst_err_code", 32'(bus.err_code), 32'd0);
        rst = 1'b0;
        repeat (2) send_byte(8'h00, 1'b0, 1'b0);

        // 1: single good frame lands in bank 1
        build(OWN, 16'h1919, 16'h1234, 0);
        exp_writes(1024);
        exp_ok();
        send_frame(-1, -1, -1, 6);
        check_val("t1_idx", 32'(bus.idx), 32'd1);
        check_val("t1_seq", 32'(bus.seq), 32'h1234);

        // 2: back-to-back good frames with a single idle byte
        do_reset();
        build(OWN, 16'h1919, 16'h0001, 3);
        exp_writes(1024);
        exp_ok();
        send_frame(-1, -1, -1, 1);
        build(OWN, 16'h1919, 16'h0002, 7);
        exp_writes(1024);
        exp_ok();
        send_frame(-1, -1, -1, 6);
        check_val("t2_idx", 32'(bus.idx), 32'd0);
        check_val("t2_seq", 32'(bus.seq), 32'd2);

        // 3: flipped payload bit fails CRC; next good frame reuses the bank
        build(OWN, 16'h1919, 16'h55AA, 5);
        fr[21] = fr[21] ^ 8'h04;
        exp_writes(1024);
        exp_err(3'd5);
        send_frame(-1, -1, -1, 2);
        build(OWN, 16'h1919, 16'h0003, 9);
        exp_writes(1024);
        exp_ok();
        send_frame(-1, -1, -1, 2);

        // 4: truncated payload, then wrong ethertype
        build(OWN, 16'h1919, 16'h0004, 11);
        exp_writes(501);
        exp_err(3'd4);
        send_frame(16 + 501, -1, -1, 2);
        build(OWN, 16'h0800, 16'h0005, 13);
        exp_err(3'd3);
        send_frame(-1, -1, -1, 2);

        // 5: RX_ER mid payload, broadcast accepted, foreign MAC rejected
        build(OWN, 16'h1919, 16'h0006, 17);
        exp_writes(10);
        exp_err(3'd6);
        send_frame(-1, 26, -1, 2);
        build(BC, 16'h1919, 16'h0007, 19);
        exp_writes(1024);
        exp_ok();
        send_frame(-1, -1, -1, 2);
        build(BAD, 16'h1919, 16'h0008, 23);
        exp_err(3'd2);
        send_frame(-1, -1, -1, 4);

        // 6: reset mid payload abandons the frame silently
        build(OWN, 16'h1919, 16'h0666, 29);
        ignore_wr = 1'b1;
        send_frame(-1, -1, 16 + 300, 4);
        check_val("t6_idx_after_rst", 32'(bus.idx), 32'd0);
        check_val("t6_seq_after_rst", 32'(bus.seq), 32'd0);
        build(OWN, 16'h1919, 16'h0777, 31);
        exp_writes(1024);
        exp_ok();
        send_frame(-1, -1, -1, 6);
        check_val("t6_idx", 32'(bus.idx), 32'd1);
        check_val("t6_seq", 32'(bus.seq), 32'h0777);

        repeat (8) send_byte(8'h00, 1'b0, 1'b0);
        check_val("writes_outstanding", 32'(wr_q.size()), 32'd0);
        check_val("pulses_outstanding", 32'(ev_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
